// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Purpose  : Round-robin arbiter that hands one requester's byte message at a
//            time to a shared byte-array sender, with count checks and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter #(
    parameter int NREQ = 3,
    parameter int MAXB = 10,
    parameter int TMO  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*8*MAXB-1:0] req_data,
    input  logic [NREQ*6-1:0]      req_count,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        err,
    output logic                   snd_start,
    output logic [8*MAXB-1:0]      snd_data,
    output logic [5:0]             snd_count,
    input  logic                   snd_busy,
    output logic                   arb_busy,
    output logic [1:0]             grant_id
);

    localparam int DW = 8 * MAXB;
    localparam int TW = $clog2(TMO + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic [5:0]      count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [NREQ-1:0] err_q, err_d;

    logic            win_vld;
    logic [1:0]      win_id;
    logic [1:0]      idx;
    logic [5:0]      win_count;
    logic            win_ok;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'(NREQ - 1)) ? 2'd0 : id + 2'd1;
    endfunction

    // First active requester at or above ptr, wrapping back to 0
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
            idx = next_id(idx);
        end
    end

    assign win_count = req_count[win_id*6 +: 6];
    assign win_ok    = (win_count != 6'd0) && (win_count <= 6'(MAXB));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        err_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (win_vld && !snd_busy) begin
                    if (win_ok) begin
                        state_d = S_START;
                        grant_d = win_id;
                        data_d  = req_data[win_id*DW +: DW];
                        count_d = win_count;
                    end else begin
                        err_d = onehot(win_id);
                        ptr_d = next_id(win_id);
                    end
                end
            end
            S_START: begin
                // The start cycle counts as the first busy-less cycle
                state_d = S_WAIT_BUSY;
                tmo_d   = TW'(1);
            end
            S_WAIT_BUSY: begin
                if (snd_busy) begin
                    state_d = S_WAIT_DONE;
                    tmo_d   = '0;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    state_d = S_IDLE;
                    tmo_d   = '0;
                    err_d   = onehot(grant_q);
                    ptr_d   = next_id(grant_q);
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!snd_busy) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                ptr_d   = next_id(grant_q);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        snd_start = (state_q == S_START);
        arb_busy  = (state_q != S_IDLE);
        done      = (state_q == S_FINISH) ? onehot(grant_q) : '0;
    end

    assign err       = err_q;
    assign snd_data  = data_q;
    assign snd_count = count_q;
    assign grant_id  = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_arbiter
// Purpose  : Directed self-checking bench for serial_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_arbiter;

    localparam int NREQ = 3;
    localparam int MAXB = 10;
    localparam int TMO  = 8;
    localparam int DW   = 8 * MAXB;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ*6-1:0]    req_count;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic                 snd_start;
    logic [DW-1:0]        snd_data;
    logic [5:0]           snd_count;
    logic                 snd_busy;
    logic                 arb_busy;
    logic [1:0]           grant_id;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int sm_cnt   = 0;
    logic sender_en;
    logic busy_force;

    localparam logic [DW-1:0] D0 = 80'h434241;
    localparam logic [DW-1:0] D1 = 80'h5A;
    localparam logic [DW-1:0] D2 = 80'h0102030405060708090A;
    localparam logic [DW-1:0] D3 = 80'h44332211;

    serial_tx_arbiter #(.NREQ(NREQ), .MAXB(MAXB), .TMO(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .req_count (req_count),
        .done      (done),
        .err       (err),
        .snd_start (snd_start),
        .snd_data  (snd_data),
        .snd_count (snd_count),
        .snd_busy  (snd_busy),
        .arb_busy  (arb_busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sender model: busy rises one cycle after start and stays up 12 cycles
    initial begin
        snd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (snd_start) n_start++;
            if (!sender_en) begin
                snd_busy = busy_force;
                sm_cnt   = 0;
            end else if (sm_cnt == 0) begin
                snd_busy = 1'b0;
                if (snd_start) sm_cnt = 1;
            end else if (sm_cnt <= 12) begin
                snd_busy = 1'b1;
                sm_cnt++;
            end else begin
                snd_busy = 1'b0;
                sm_cnt   = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expects snd_start after lat cycles, then a 12-cycle busy window and done
    task automatic run_xfer(input logic [1:0] id, input int lat, input logic [5:0] ecnt,
                            input logic [DW-1:0] edata, input bit mutate);
        int n0;
        logic [NREQ-1:0] oh;
        n0 = n_start;
        oh = 3'b001 << id;
        repeat (lat) tick;
        chk("start", 128'(snd_start), 128'(1));
        chk("grant", 128'(grant_id), 128'(id));
        chk("count", 128'(snd_count), 128'(ecnt));
        chk("data", 128'(snd_data), 128'(edata));
        chk("abusy_xfer", 128'(arb_busy), 128'(1));
        chk("err_start", 128'(err), 128'(0));
        tick;
        chk("start_one_cycle", 128'(snd_start), 128'(0));
        repeat (4) tick;
        if (mutate) begin
            req[id] = 1'b0;
            req_data[id*DW +: DW] = '1;
        end
        tick;
        chk("data_hold", 128'(snd_data), 128'(edata));
        chk("count_hold", 128'(snd_count), 128'(ecnt));
        repeat (7) tick;
        chk("done_early", 128'(done), 128'(0));
        tick;
        chk("done", 128'(done), 128'(oh));
        chk("err_with_done", 128'(err), 128'(0));
        chk("n_start", 128'(n_start - n0), 128'(1));
    endtask

    initial begin
        reset      = 1'b0;
        req        = '0;
        req_data   = '0;
        req_count  = '0;
        sender_en  = 1'b1;
        busy_force = 1'b0;
        tick;
        tick;
        chk("rst_start", 128'(snd_start), 128'(0));
        chk("rst_abusy", 128'(arb_busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_grant", 128'(grant_id), 128'(0));
        chk("rst_data", 128'(snd_data), 128'(0));
        chk("rst_count", 128'(snd_count), 128'(0));
        reset = 1'b1;

        // Single send
        req_data[0*DW +: DW] = D0;
        req_count[0*6 +: 6]  = 6'd3;
        req = 3'b001;
        run_xfer(2'd0, 1, 6'd3, D0, 1'b0);
        req = '0;

        // Bad counts: zero and MAXB+1
        begin
            int n0;
            n0 = n_start;
            req_count[1*6 +: 6] = 6'd0;
            req = 3'b010;
            tick;
            chk("bad0_early", 128'(err), 128'(0));
            tick;
            chk("bad0_err", 128'(err), 128'(3'b010));
            chk("bad0_abusy", 128'(arb_busy), 128'(0));
            chk("bad0_start", 128'(snd_start), 128'(0));
            req = '0;
            tick;
            chk("bad0_clear", 128'(err), 128'(0));
            req_count[1*6 +: 6] = 6'd11;
            req = 3'b010;
            tick;
            chk("bad11_err", 128'(err), 128'(3'b010));
            chk("bad11_abusy", 128'(arb_busy), 128'(0));
            req = '0;
            tick;
            chk("bad11_clear", 128'(err), 128'(0));
            chk("bad_nstart", 128'(n_start - n0), 128'(0));
        end

        // Sender never raises busy
        sender_en = 1'b0;
        busy_force = 1'b0;
        req_data[2*DW +: DW] = D2;
        req_count[2*6 +: 6]  = 6'd2;
        req = 3'b100;
        tick;
        chk("tmo_start", 128'(snd_start), 128'(1));
        chk("tmo_grant", 128'(grant_id), 128'(2));
        repeat (7) tick;
        chk("tmo_early", 128'(err), 128'(0));
        chk("tmo_abusy_wait", 128'(arb_busy), 128'(1));
        tick;
        chk("tmo_err", 128'(err), 128'(3'b100));
        chk("tmo_abusy", 128'(arb_busy), 128'(0));
        chk("tmo_done", 128'(done), 128'(0));
        sender_en = 1'b1;
        req_count[2*6 +: 6] = 6'd10;
        run_xfer(2'd2, 1, 6'd10, D2, 1'b0);
        req = '0;

        // Sender busy externally while idle
        sender_en  = 1'b0;
        busy_force = 1'b1;
        req = 3'b001;
        repeat (3) begin
            tick;
            chk("ext_busy_start", 128'(snd_start), 128'(0));
            chk("ext_busy_abusy", 128'(arb_busy), 128'(0));
        end
        busy_force = 1'b0;
        sender_en  = 1'b1;
        run_xfer(2'd0, 1, 6'd3, D0, 1'b0);

        // Request dropped and data changed mid-transfer
        req_data[0*DW +: DW] = D3;
        req_count[0*6 +: 6]  = 6'd4;
        run_xfer(2'd0, 2, 6'd4, D3, 1'b1);

        // Reset during WAIT_DONE
        req = 3'b100;
        repeat (2) tick;
        chk("rmid_start", 128'(snd_start), 128'(1));
        chk("rmid_grant", 128'(grant_id), 128'(2));
        repeat (5) tick;
        #2;
        reset = 1'b0;
        sender_en = 1'b0;
        #1;
        chk("rmid_abusy", 128'(arb_busy), 128'(0));
        chk("rmid_grant0", 128'(grant_id), 128'(0));
        chk("rmid_data", 128'(snd_data), 128'(0));
        chk("rmid_count", 128'(snd_count), 128'(0));
        chk("rmid_done", 128'(done), 128'(0));
        chk("rmid_err", 128'(err), 128'(0));
        tick;
        chk("rmid_done_hold", 128'(done), 128'(0));
        tick;
        req_data[0*DW +: DW] = D0;
        req_count[0*6 +: 6]  = 6'd3;
        req_data[1*DW +: DW] = D1;
        req_count[1*6 +: 6]  = 6'd1;
        reset = 1'b1;
        sender_en = 1'b1;
        req = 3'b111;

        // Fairness with every requester held high
        run_xfer(2'd0, 1, 6'd3, D0, 1'b0);
        run_xfer(2'd1, 2, 6'd1, D1, 1'b0);
        run_xfer(2'd2, 2, 6'd10, D2, 1'b0);
        run_xfer(2'd0, 2, 6'd3, D0, 1'b0);
        run_xfer(2'd1, 2, 6'd1, D1, 1'b0);
        run_xfer(2'd2, 2, 6'd10, D2, 1'b0);
        req = '0;
        repeat (2) tick;
        chk("end_abusy", 128'(arb_busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
